// File: rtl/sha2_chain_engine.sv
// SHA-224/256/384/512 compression engine with multi-block hash chaining.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   pre-padded message block handshake
//   in_mode             0=SHA-224 1=SHA-256 2=SHA-384 3=SHA-512 (sampled on first block)
//   in_first/in_last    message framing flags
//   in_block            1024-bit big-endian block (32-bit modes use [511:0])
//   out_valid/out_ready digest handshake
//   out_hash            right-aligned digest, unused upper bits zero
//   err_mode            sticky flag, illegal mode requested
//   abort               (only with SHA2_CHAIN_ABORT_EN) drop all work, back to idle
//
// Optional feature macro: SHA2_CHAIN_ABORT_EN adds the abort input.
module sha2_chain_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned EN_SHA512        = 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SHA2_CHAIN_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_mode,
    input  logic          in_first,
    input  logic          in_last,
    input  logic [1023:0] in_block,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [511:0]  out_hash,
    output logic          err_mode
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
        $fatal(1, "ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    // SHA-256 round constants are the upper halves of the SHA-512 ones.
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [63:0] IV [4][8] = '{
        '{64'hc1059ed8, 64'h367cd507, 64'h3070dd17, 64'hf70e5939,
          64'hffc00b31, 64'h68581511, 64'h64f98fa7, 64'hbefa4fa4},
        '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
          64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19},
        '{64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
          64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4},
        '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
          64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179}
    };

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StOut} state_e;

    function automatic logic wide(input logic [1:0] mode);
        return (EN_SHA512 != 0) && mode[1];
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x, input logic w64);
        if (w64) return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
        return {32'b0, ror32(x[31:0], 2) ^ ror32(x[31:0], 13) ^ ror32(x[31:0], 22)};
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x, input logic w64);
        if (w64) return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
        return {32'b0, ror32(x[31:0], 6) ^ ror32(x[31:0], 11) ^ ror32(x[31:0], 25)};
    endfunction

    function automatic logic [63:0] small_sigma0(input logic [63:0] x, input logic w64);
        if (w64) return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
        return {32'b0, ror32(x[31:0], 7) ^ ror32(x[31:0], 18) ^ (x[31:0] >> 3)};
    endfunction

    function automatic logic [63:0] small_sigma1(input logic [63:0] x, input logic w64);
        if (w64) return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
        return {32'b0, ror32(x[31:0], 17) ^ ror32(x[31:0], 19) ^ (x[31:0] >> 10)};
    endfunction

    state_e       state_q, state_d;
    logic [1:0]   mode_q, mode_d;
    logic         last_q, last_d, chain_q, chain_d, err_q, err_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [63:0]  w_q [16], w_d [16];
    logic [63:0]  work_q [8], work_d [8];
    logic [63:0]  h_q [8], h_d [8];
    logic [511:0] hash_q, hash_d;

    logic         abort_req, wide_q, new_msg, load_wide;
    logic [1:0]   load_mode;
    logic [6:0]   last_cnt;
    logic [63:0]  mask;
    logic [63:0]  hn [8];
    logic [511:0] digest;
    logic [63:0]  rnd_work [8];
    logic [63:0]  rnd_w [16];
    logic [63:0]  t1, t2, nw, kt;
    logic [6:0]   idx;

`ifdef SHA2_CHAIN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign wide_q   = wide(mode_q);
    assign mask     = wide_q ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    assign last_cnt = wide_q ? 7'(80 - ROUNDS_PER_CYCLE) : 7'(64 - ROUNDS_PER_CYCLE);

    // Unrolled rounds; the W window slides one word per round so w[0] is always W[t].
    always_comb begin
        rnd_work = work_q;
        rnd_w    = w_q;
        t1       = '0;
        t2       = '0;
        nw       = '0;
        kt       = '0;
        idx      = cnt_q;
        for (int j = 0; j < int'(ROUNDS_PER_CYCLE); j++) begin
            idx = cnt_q + 7'(j);
            kt  = wide_q ? K[idx] : {32'b0, K[idx][63:32]};
            t1  = rnd_work[7] + big_sigma1(rnd_work[4], wide_q)
                + ((rnd_work[4] & rnd_work[5]) ^ (~rnd_work[4] & rnd_work[6])) + kt + rnd_w[0];
            t2  = big_sigma0(rnd_work[0], wide_q) + ((rnd_work[0] & rnd_work[1])
                ^ (rnd_work[0] & rnd_work[2]) ^ (rnd_work[1] & rnd_work[2]));
            nw  = small_sigma1(rnd_w[14], wide_q) + rnd_w[9]
                + small_sigma0(rnd_w[1], wide_q) + rnd_w[0];
            rnd_work[7] = rnd_work[6];
            rnd_work[6] = rnd_work[5];
            rnd_work[5] = rnd_work[4];
            rnd_work[4] = (rnd_work[3] + t1) & mask;
            rnd_work[3] = rnd_work[2];
            rnd_work[2] = rnd_work[1];
            rnd_work[1] = rnd_work[0];
            rnd_work[0] = (t1 + t2) & mask;
            for (int k = 0; k < 15; k++) rnd_w[k] = rnd_w[k + 1];
            rnd_w[15] = nw & mask;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) hn[i] = (h_q[i] + work_q[i]) & mask;
        case (mode_q)
            2'd0:    digest = {288'b0, hn[0][31:0], hn[1][31:0], hn[2][31:0], hn[3][31:0],
                               hn[4][31:0], hn[5][31:0], hn[6][31:0]};
            2'd1:    digest = {256'b0, hn[0][31:0], hn[1][31:0], hn[2][31:0], hn[3][31:0],
                               hn[4][31:0], hn[5][31:0], hn[6][31:0], hn[7][31:0]};
            2'd2:    digest = {128'b0, hn[0], hn[1], hn[2], hn[3], hn[4], hn[5]};
            default: digest = {hn[0], hn[1], hn[2], hn[3], hn[4], hn[5], hn[6], hn[7]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        last_d    = last_q;
        chain_d   = chain_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        work_d    = work_q;
        h_d       = h_q;
        hash_d    = hash_q;
        // A block continuing a live chain keeps the mode of the message it belongs to.
        new_msg   = in_first || !chain_q;
        load_mode = new_msg ? in_mode : mode_q;
        load_wide = wide(load_mode);
        if (abort_req) begin
            state_d = StIdle;
            chain_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (new_msg && in_mode[1] && EN_SHA512 == 0) begin
                            err_d = 1'b1;
                        end else begin
                            mode_d  = load_mode;
                            last_d  = in_last;
                            cnt_d   = '0;
                            state_d = StRound;
                            for (int i = 0; i < 16; i++) begin
                                w_d[i] = load_wide ? in_block[1023 - 64 * i -: 64]
                                                   : {32'b0, in_block[511 - 32 * i -: 32]};
                            end
                            for (int i = 0; i < 8; i++) begin
                                if (new_msg) h_d[i] = IV[in_mode][i];
                                work_d[i] = new_msg ? IV[in_mode][i] : h_q[i];
                            end
                        end
                    end
                end
                StRound: begin
                    work_d = rnd_work;
                    w_d    = rnd_w;
                    if (cnt_q == last_cnt) begin
                        cnt_d   = '0;
                        state_d = StFinal;
                    end else begin
                        cnt_d = cnt_q + 7'(ROUNDS_PER_CYCLE);
                    end
                end
                StFinal: begin
                    h_d = hn;
                    if (last_q) begin
                        hash_d  = digest;
                        chain_d = 1'b0;
                        state_d = StOut;
                    end else begin
                        chain_d = 1'b1;
                        state_d = StIdle;
                    end
                end
                StOut: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= '0;
            last_q  <= 1'b0;
            chain_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            w_q     <= '{default: '0};
            work_q  <= '{default: '0};
            h_q     <= '{default: '0};
            hash_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            chain_q <= chain_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            work_q  <= work_d;
            h_q     <= h_d;
            hash_q  <= hash_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && !abort_req;
    assign out_valid = (state_q == StOut);
    assign out_hash  = hash_q;
    assign err_mode  = err_q;

endmodule

// File: tb/tb_sha2_chain_engine.sv
// Directed bench for sha2_chain_engine: known-answer digests, chaining, latency,
// backpressure, mid-round reset and illegal-mode handling.
// Instance 0: 1 round/cycle, instance 1: 4 rounds/cycle, instance 2: no 64-bit datapath.
module tb_sha2_chain_engine;

    localparam logic [1023:0] BLK_ABC256 = {512'b0, 32'h61626380, 448'b0, 32'h00000018};
    localparam logic [1023:0] BLK_ABC512 = {64'h6162638000000000, 896'b0, 64'h18};
    localparam logic [1023:0] BLK_2A = {512'b0,
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [1023:0] BLK_2B = {512'b0, 480'b0, 32'h000001c0};

    localparam logic [511:0] EXP_256 = {256'b0,
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
    localparam logic [511:0] EXP_224 = {288'b0,
        224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7};
    localparam logic [511:0] EXP_2BLK = {256'b0,
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
    localparam logic [511:0] EXP_512 = {
        256'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a,
        256'h2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f};

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    in_mode;
    logic          in_first, in_last;
    logic [1023:0] in_block;
    logic          in_valid  [3];
    logic          out_ready [3];
    logic          in_ready  [3];
    logic          out_valid [3];
    logic          err_mode  [3];
    logic [511:0]  out_hash  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sha2_chain_engine #(.ROUNDS_PER_CYCLE(1), .EN_SHA512(1)) u_dut0 (
        .clk(clk), .rst(rst),
`ifdef SHA2_CHAIN_ABORT_EN
        .abort(1'b0),
`endif
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode),
        .in_first(in_first), .in_last(in_last), .in_block(in_block),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_hash(out_hash[0]),
        .err_mode(err_mode[0])
    );

    sha2_chain_engine #(.ROUNDS_PER_CYCLE(4), .EN_SHA512(1)) u_dut1 (
        .clk(clk), .rst(rst),
`ifdef SHA2_CHAIN_ABORT_EN
        .abort(1'b0),
`endif
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode),
        .in_first(in_first), .in_last(in_last), .in_block(in_block),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_hash(out_hash[1]),
        .err_mode(err_mode[1])
    );

    sha2_chain_engine #(.ROUNDS_PER_CYCLE(1), .EN_SHA512(0)) u_dut2 (
        .clk(clk), .rst(rst),
`ifdef SHA2_CHAIN_ABORT_EN
        .abort(1'b0),
`endif
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_mode(in_mode),
        .in_first(in_first), .in_last(in_last), .in_block(in_block),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_hash(out_hash[2]),
        .err_mode(err_mode[2])
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a block and let exactly one edge accept it.
    task automatic send(input int s, input logic [1:0] mode, input logic first,
                        input logic last, input logic [1023:0] blk, input string tag);
        in_mode  = mode;
        in_first = first;
        in_last  = last;
        in_block = blk;
        in_valid[s] = 1'b1;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 512'(in_ready[s]), 512'd1);
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_valid(input int s, output int n);
        n = 0;
        while (!out_valid[s] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_out(input int s, input logic [511:0] exp, input int lat,
                            input string tag);
        int n;
        wait_valid(s, n);
        check_eq({tag, " latency"}, 512'(n), 512'(lat));
        check_eq({tag, " hash"}, out_hash[s], exp);
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[s] = 1'b0;
        check_eq({tag, " out_valid drop"}, 512'(out_valid[s]), 512'd0);
        check_eq({tag, " hash kept"}, out_hash[s], exp);
    endtask

    task automatic wait_ready(input int s, input int lat, input string tag);
        int n = 0;
        while (!in_ready[s] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, " ready latency"}, 512'(n), 512'(lat));
        check_eq({tag, " no out_valid"}, 512'(out_valid[s]), 512'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        in_valid  = '{1'b0, 1'b0, 1'b0};
        out_ready = '{1'b0, 1'b0, 1'b0};
        in_mode   = 2'd0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_block  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset in_ready", 512'(in_ready[0]), 512'd1);
        check_eq("reset out_valid", 512'(out_valid[0]), 512'd0);
        check_eq("reset out_hash", out_hash[0], 512'd0);
        check_eq("reset err_mode", 512'(err_mode[0]), 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(0, 2'd1, 1'b1, 1'b1, BLK_ABC256, "sha256");
        wait_out(0, EXP_256, 65, "sha256");

        send(0, 2'd0, 1'b1, 1'b1, BLK_ABC256, "sha224");
        wait_out(0, EXP_224, 65, "sha224");

        // Second block carries a different mode that must be ignored.
        send(0, 2'd1, 1'b1, 1'b0, BLK_2A, "chain b1");
        wait_ready(0, 65, "chain b1");
        send(0, 2'd0, 1'b0, 1'b1, BLK_2B, "chain b2");
        wait_out(0, EXP_2BLK, 65, "chain");

        // in_first on a live chain restarts it.
        send(0, 2'd1, 1'b1, 1'b0, BLK_2A, "restart b1");
        wait_ready(0, 65, "restart b1");
        send(0, 2'd1, 1'b1, 1'b1, BLK_ABC256, "restart");
        wait_out(0, EXP_256, 65, "restart");

        send(0, 2'd3, 1'b1, 1'b1, BLK_ABC512, "sha512 r1");
        wait_out(0, EXP_512, 81, "sha512 r1");
        send(1, 2'd3, 1'b1, 1'b1, BLK_ABC512, "sha512 r4");
        wait_out(1, EXP_512, 21, "sha512 r4");

        // Backpressure: digest held, no new block accepted until it is consumed.
        send(0, 2'd1, 1'b1, 1'b1, BLK_ABC256, "bp");
        wait_valid(0, n);
        check_eq("bp latency", 512'(n), 512'd65);
        in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("bp in_ready", 512'(in_ready[0]), 512'd0);
            check_eq("bp out_valid", 512'(out_valid[0]), 512'd1);
            check_eq("bp hash", out_hash[0], EXP_256);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        check_eq("bp ready after consume", 512'(in_ready[0]), 512'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check_eq("bp accepted", 512'(in_ready[0]), 512'd0);
        wait_out(0, EXP_256, 65, "bp next");

        // Reset in the middle of a 64-bit message.
        send(0, 2'd3, 1'b1, 1'b1, BLK_ABC512, "rst pre");
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst out_valid", 512'(out_valid[0]), 512'd0);
        check_eq("rst in_ready", 512'(in_ready[0]), 512'd1);
        check_eq("rst out_hash", out_hash[0], 512'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 2'd1, 1'b1, 1'b1, BLK_ABC256, "post rst");
        wait_out(0, EXP_256, 65, "post rst");

        // Without the 64-bit datapath, mode 3 is dropped and flagged.
        check_eq("err before", 512'(err_mode[2]), 512'd0);
        send(2, 2'd3, 1'b1, 1'b1, BLK_ABC512, "err");
        check_eq("err flag", 512'(err_mode[2]), 512'd1);
        check_eq("err stays idle", 512'(in_ready[2]), 512'd1);
        seen = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (out_valid[2]) seen++;
        end
        check_eq("err no out_valid", 512'(seen), 512'd0);
        check_eq("err sticky", 512'(err_mode[2]), 512'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
